// File: rtl/ro_pair_counter.sv
// ---------------------------------------------------------------------------
// ro_pair_counter
//
// Measurement stage for a dual ring-oscillator PUF bank. On an accepted start
// it enables both RO banks, lets the selected oscillators settle for SETTLE
// clk cycles, and then counts rising edges of one bank-1 RO and one bank-2 RO
// over a programmable window of clk cycles. It then disables the banks and
// reports both counts and a 1-bit response (count_a > count_b).
//
// rst is asserted asynchronously. Its release is expected to be synchronous
// to clk, so no internal reset synchronizer is added here.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   start          in   measurement request, sampled only while idle
//   sel_a          in   bank-1 RO index, latched on accepted start
//   sel_b          in   bank-2 RO index, latched on accepted start
//   window         in   count window in clk cycles, latched on accepted start
//   ro1_in         in   bank-1 RO outputs (asynchronous to clk)
//   ro2_in         in   bank-2 RO outputs (asynchronous to clk)
//   ro_activate_1  out  bank-1 enable, high during warm-up and counting
//   ro_activate_2  out  bank-2 enable, high during warm-up and counting
//   busy           out  high during warm-up and counting
//   done           out  one-cycle pulse when results are valid
//   count_a        out  saturating rising-edge count of selected bank-1 RO
//   count_b        out  saturating rising-edge count of selected bank-2 RO
//   response       out  1 iff count_a > count_b (ties give 0)
// ---------------------------------------------------------------------------
module ro_pair_counter #(
  parameter int N_RO   = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] sel_a,
  input  logic [SEL_W-1:0] sel_b,
  input  logic [WIN_W-1:0] window,
  input  logic [N_RO-1:0]  ro1_in,
  input  logic [N_RO-1:0]  ro2_in,
  output logic             ro_activate_1,
  output logic             ro_activate_2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             response
);

  // The shared timer holds either the warm-up length or the window length.
  localparam int ST_W  = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam int TMR_W = (WIN_W > ST_W) ? WIN_W : ST_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel_a;
  logic [SEL_W-1:0] r_sel_b;
  logic [WIN_W-1:0] r_win;
  logic [TMR_W-1:0] r_tmr;
  logic             r_act;
  logic             r_done;
  logic             r_resp;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  // Synchronizer and edge-history flops, one chain per selected RO.
  logic r_sync_a_p0, r_sync_a_p1, r_hist_a_p2;
  logic r_sync_b_p0, r_sync_b_p1, r_hist_b_p2;

  logic             w_ro_a;
  logic             w_ro_b;
  logic             w_edge_a;
  logic             w_edge_b;
  logic [CNT_W-1:0] w_next_a;
  logic [CNT_W-1:0] w_next_b;

  // Counters clamp at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      return cnt + CNT_W'(1);
    end
    return cnt;
  endfunction

  // Stage 0: select the RO through the latched index. The mux runs before
  // the synchronizer so only one async signal per bank is synchronized.
  assign w_ro_a = ro1_in[r_sel_a];
  assign w_ro_b = ro2_in[r_sel_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_a_p0 <= 1'b0;
      r_sync_a_p1 <= 1'b0;
      r_hist_a_p2 <= 1'b0;
      r_sync_b_p0 <= 1'b0;
      r_sync_b_p1 <= 1'b0;
      r_hist_b_p2 <= 1'b0;
    end else begin
      // Stage 1/2: two-flop synchronizer; stage 3: history for edge detect.
      r_sync_a_p0 <= w_ro_a;
      r_sync_a_p1 <= r_sync_a_p0;
      r_hist_a_p2 <= r_sync_a_p1;
      r_sync_b_p0 <= w_ro_b;
      r_sync_b_p1 <= r_sync_b_p0;
      r_hist_b_p2 <= r_sync_b_p1;
    end
  end

  assign w_edge_a = r_sync_a_p1 & ~r_hist_a_p2;
  assign w_edge_b = r_sync_b_p1 & ~r_hist_b_p2;

  assign w_next_a = sat_inc(r_cnt_a, w_edge_a);
  assign w_next_b = sat_inc(r_cnt_b, w_edge_b);

  // Control FSM with registered outputs. r_act is set on the edge entering
  // WARMUP and cleared on the edge entering DONE, so it is high exactly
  // during WARMUP and COUNT and doubles as busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_win   <= '0;
      r_tmr   <= '0;
      r_act   <= 1'b0;
      r_done  <= 1'b0;
      r_resp  <= 1'b0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel_a <= sel_a;
            r_sel_b <= sel_b;
            r_win   <= window;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_tmr   <= TMR_W'(SETTLE - 1);
            r_act   <= 1'b1;
            r_state <= S_WARMUP;
          end
        end

        S_WARMUP: begin
          if (r_tmr == '0) begin
            if (r_win == '0) begin
              // Empty window: straight to results with zero counts.
              r_state <= S_DONE;
              r_act   <= 1'b0;
              r_done  <= 1'b1;
              r_resp  <= (r_cnt_a > r_cnt_b);
            end else begin
              r_state <= S_COUNT;
              r_tmr   <= TMR_W'(r_win) - TMR_W'(1);
            end
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end

        S_COUNT: begin
          r_cnt_a <= w_next_a;
          r_cnt_b <= w_next_b;
          if (r_tmr == '0) begin
            // Response uses the post-increment counts so it is valid
            // together with done.
            r_state <= S_DONE;
            r_act   <= 1'b0;
            r_done  <= 1'b1;
            r_resp  <= (w_next_a > w_next_b);
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_act   <= 1'b0;
        end
      endcase
    end
  end

  assign ro_activate_1 = r_act;
  assign ro_activate_2 = r_act;
  assign busy          = r_act;
  assign done          = r_done;
  assign count_a       = r_cnt_a;
  assign count_b       = r_cnt_b;
  assign response      = r_resp;

endmodule

// File: tb/tb_ro_pair_counter.sv
// ---------------------------------------------------------------------------
// tb_ro_pair_counter
//
// Two instances of ro_pair_counter share all inputs: one with the default
// 16-bit counters and one with 4-bit counters to exercise saturation.
// RO waveforms are generated synchronously to clk from per-RO periods so the
// expected edge counts are deterministic. A behavioural model derives the
// expected outputs from the measurement timeline (accept edge, warm-up length,
// window) and from the recorded RO samples; a compare process checks every
// output of both instances on every falling clock edge. Directed sequences
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ro_pair_counter;

  localparam int N_RO    = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 4;
  localparam int WIN_W   = 16;
  localparam int SETTLE  = 4;
  localparam int HDEPTH  = 8192;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             start  = 1'b0;
  logic [SEL_W-1:0] sel_a  = '0;
  logic [SEL_W-1:0] sel_b  = '0;
  logic [WIN_W-1:0] window = '0;
  logic [N_RO-1:0]  ro1_in = '0;
  logic [N_RO-1:0]  ro2_in = '0;

  logic               act1, act2, busy, done, response;
  logic [CNT_W-1:0]   count_a, count_b;
  logic               act1_s, act2_s, busy_s, done_s, response_s;
  logic [CNT_W_S-1:0] count_a_s, count_b_s;

  int checks = 0;
  int errors = 0;

  ro_pair_counter #(
    .N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b),
    .window(window), .ro1_in(ro1_in), .ro2_in(ro2_in),
    .ro_activate_1(act1), .ro_activate_2(act2), .busy(busy), .done(done),
    .count_a(count_a), .count_b(count_b), .response(response)
  );

  ro_pair_counter #(
    .N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W_S), .WIN_W(WIN_W), .SETTLE(SETTLE)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b),
    .window(window), .ro1_in(ro1_in), .ro2_in(ro2_in),
    .ro_activate_1(act1_s), .ro_activate_2(act2_s), .busy(busy_s), .done(done_s),
    .count_a(count_a_s), .count_b(count_b_s), .response(response_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // ---------------- RO waveform generator ----------------
  // Period 0 means the RO is held low. High for the first half of each period.
  int per1 [N_RO] = '{default: 0};
  int per2 [N_RO] = '{default: 0};
  int tick = 0;

  always @(negedge clk) begin
    tick++;
    for (int i = 0; i < N_RO; i++) begin
      ro1_in[i] = (per1[i] == 0) ? 1'b0 : (((tick % per1[i]) < per1[i] / 2) ? 1'b1 : 1'b0);
      ro2_in[i] = (per2[i] == 0) ? 1'b0 : (((tick % per2[i]) < per2[i] / 2) ? 1'b1 : 1'b0);
    end
  end

  // ---------------- behavioural model ----------------
  // A measurement accepted at clock edge A is in warm-up for the SETTLE
  // periods after edges A..A+SETTLE-1, counting for the next m_win periods,
  // and shows done in the period after edge A+SETTLE+m_win. The selected RO
  // is seen through a 3-flop delay (2 sync + history), so a rising transition
  // between samples j-1 and j is counted during the period after edge j+1.
  logic [N_RO-1:0]  h1 [HDEPTH];
  logic [N_RO-1:0]  h2 [HDEPTH];
  int               cyc   = 0;
  int               m_acc = -1;
  int               m_win = 0;
  int               m_d;
  logic [SEL_W-1:0] m_sa, m_sb;
  int               raw_a = 0, raw_b = 0;
  logic             e_busy = 1'b0, e_done = 1'b0, e_resp = 1'b0, e_resp_s = 1'b0;

  function automatic logic rise(input logic [N_RO-1:0] cur, input logic [N_RO-1:0] prv,
                                input logic [SEL_W-1:0] s);
    return cur[s] & ~prv[s];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc    = -1;
      raw_a    = 0;
      raw_b    = 0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_resp   = 1'b0;
      e_resp_s = 1'b0;
    end else begin
      cyc++;
      h1[cyc % HDEPTH] = ro1_in;
      h2[cyc % HDEPTH] = ro2_in;
      if (start && (m_acc < 0 || (cyc - 1) > (m_acc + SETTLE + m_win))) begin
        m_acc = cyc;
        m_win = int'(window);
        m_sa  = sel_a;
        m_sb  = sel_b;
        raw_a = 0;
        raw_b = 0;
      end else if (m_acc >= 0) begin
        m_d = cyc - m_acc;
        if ((m_d - 1) >= SETTLE && (m_d - 1) < SETTLE + m_win) begin
          raw_a += int'(rise(h1[(cyc - 2) % HDEPTH], h1[(cyc - 3) % HDEPTH], m_sa));
          raw_b += int'(rise(h2[(cyc - 2) % HDEPTH], h2[(cyc - 3) % HDEPTH], m_sb));
        end
      end
      m_d    = (m_acc < 0) ? -1 : (cyc - m_acc);
      e_busy = (m_d >= 0) && (m_d < SETTLE + m_win);
      e_done = (m_d >= 0) && (m_d == SETTLE + m_win);
      if (e_done) begin
        e_resp   = sat(raw_a, CNT_W)   > sat(raw_b, CNT_W);
        e_resp_s = sat(raw_a, CNT_W_S) > sat(raw_b, CNT_W_S);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("act1",       act1,       e_busy);
    chk("act2",       act2,       e_busy);
    chk("busy",       busy,       e_busy);
    chk("done",       done,       e_done);
    chk("count_a",    count_a,    sat(raw_a, CNT_W));
    chk("count_b",    count_b,    sat(raw_b, CNT_W));
    chk("response",   response,   e_resp);
    chk("busy_s",     busy_s,     e_busy);
    chk("act1_s",     act1_s,     e_busy);
    chk("act2_s",     act2_s,     e_busy);
    chk("done_s",     done_s,     e_done);
    chk("count_a_s",  count_a_s,  sat(raw_a, CNT_W_S));
    chk("count_b_s",  count_b_s,  sat(raw_b, CNT_W_S));
    chk("response_s", response_s, e_resp_s);
  end

  // ---------------- directed stimulus ----------------
  task automatic go(input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sb,
                    input logic [WIN_W-1:0] w);
    @(negedge clk);
    start  = 1'b1;
    sel_a  = sa;
    sel_b  = sb;
    window = w;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Returns the number of falling edges from the period after the accept
  // edge until done is seen (SETTLE + window when timing is right).
  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < limit);
    chk("done_seen", done, 1);
  endtask

  task automatic set_pair(input int pa, input int pb);
    for (int i = 0; i < N_RO; i++) begin
      per1[i] = 0;
      per2[i] = 0;
    end
    per1[2] = pa;
    per2[5] = pb;
  endtask

  int n;
  int pulses;
  int first_t, second_t;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count_a", count_a, 0);
    chk("rst_busy",    busy,    0);
    rst = 1'b0;

    // Reset mid-run: outputs drop at once, next start accepted.
    set_pair(8, 4);
    go(3'd2, 3'd5, 16'd64);
    repeat (20) @(negedge clk);
    sel_a  = 3'd7;
    sel_b  = 3'd1;
    window = 16'd999;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_act1",  act1,    0);
    chk("rst_async_act2",  act2,    0);
    chk("rst_async_busy",  busy,    0);
    chk("rst_async_cnt_a", count_a, 0);
    chk("rst_async_cnt_b", count_b, 0);
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b1;
    sel_a  = 3'd2;
    sel_b  = 3'd5;
    window = 16'd16;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_accept", busy, 1);
    wait_done(100, n);
    chk("post_rst_latency", n, SETTLE + 16);

    // Basic compare: period 8 vs period 4, window 64.
    set_pair(8, 4);
    go(3'd2, 3'd5, 16'd64);
    wait_done(200, n);
    chk("basic_latency",   n,         68);
    chk("basic_count_a",   count_a,   8);
    chk("basic_count_b",   count_b,   16);
    chk("basic_response",  response,  0);
    chk("basic_act_off",   act1,      0);
    chk("basic_count_b_s", count_b_s, 15);

    // Swapped periods.
    set_pair(4, 8);
    go(3'd2, 3'd5, 16'd64);
    wait_done(200, n);
    chk("swap_count_a",  count_a,  16);
    chk("swap_count_b",  count_b,  8);
    chk("swap_response", response, 1);

    // Tie.
    set_pair(8, 8);
    go(3'd2, 3'd5, 16'd64);
    wait_done(200, n);
    chk("tie_count_a",  count_a,  8);
    chk("tie_count_b",  count_b,  8);
    chk("tie_response", response, 0);

    // Saturation: 32 edges on each side.
    set_pair(4, 4);
    go(3'd2, 3'd5, 16'd128);
    wait_done(300, n);
    chk("sat_count_a_wide", count_a,    32);
    chk("sat_count_a",      count_a_s,  15);
    chk("sat_count_b",      count_b_s,  15);
    chk("sat_response",     response_s, 0);

    // start held high: one measurement per accept, retrigger after DONE.
    @(negedge clk);
    start    = 1'b1;
    sel_a    = 3'd2;
    sel_b    = 3'd5;
    window   = 16'd16;
    pulses   = 0;
    first_t  = 0;
    second_t = 0;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (pulses == 1) first_t = i;
        if (pulses == 2) second_t = i;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("held_pulses",  pulses,             3);
    chk("held_first",   first_t,            21);
    chk("held_spacing", second_t - first_t, 22);

    // sel/window changes after acceptance have no effect.
    for (int i = 0; i < N_RO; i++) begin
      per1[i] = 2;
      per2[i] = 2;
    end
    per1[1] = 8;
    per2[3] = 16;
    go(3'd1, 3'd3, 16'd32);
    repeat (10) @(negedge clk);
    sel_a  = 3'd6;
    sel_b  = 3'd0;
    window = 16'd5;
    wait_done(200, n);
    chk("chg_latency",  n,        SETTLE + 32 - 10);
    chk("chg_count_a",  count_a,  4);
    chk("chg_count_b",  count_b,  2);
    chk("chg_response", response, 1);

    // Empty window.
    set_pair(8, 4);
    go(3'd2, 3'd5, 16'd0);
    wait_done(50, n);
    chk("win0_latency",  n,        4);
    chk("win0_count_a",  count_a,  0);
    chk("win0_count_b",  count_b,  0);
    chk("win0_response", response, 0);

    // Reset at the COUNT midpoint: no done pulse afterwards.
    go(3'd2, 3'd5, 16'd64);
    repeat (SETTLE + 32) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_act1",    act1,    0);
    chk("mid_act2",    act2,    0);
    chk("mid_count_a", count_a, 0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("mid_no_done", pulses, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Measurement stage directly downstream of the dual ring-oscillator bank (two banks of 8 ROs, each bank enabled by its own activate line).
- On `start`, enables both banks, selects one RO from bank 1 and one from bank 2, and counts rising edges of each over a programmable window of `clk` cycles.
- Then disables the ROs and reports both counts and a 1-bit comparison response (the PUF bit).
- Drives the bank activate lines itself, so ROs run only while a measurement is in progress.

Parameters:
- N_RO, 8: ROs per bank; width of each RO input bus.
- SEL_W, 3: select width; clog2(N_RO).
- CNT_W, 16: edge-counter width.
- WIN_W, 16: window-length width.
- SETTLE, 4: warm-up cycles after activation before counting starts; minimum 3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  measurement request; sampled only in IDLE.
- sel_a  in  SEL_W  bank-1 RO index; latched on accepted start.
- sel_b  in  SEL_W  bank-2 RO index; latched on accepted start.
- window  in  WIN_W  count window in clk cycles; latched on accepted start.
- ro1_in  in  N_RO  bank-1 RO outputs; asynchronous to clk.
- ro2_in  in  N_RO  bank-2 RO outputs; asynchronous to clk.
- ro_activate_1  out  1  bank-1 enable.
- ro_activate_2  out  1  bank-2 enable.
- busy  out  1  high during WARMUP and COUNT.
- done  out  1  one-cycle pulse when results are valid.
- count_a  out  CNT_W  rising edges of the selected bank-1 RO.
- count_b  out  CNT_W  rising edges of the selected bank-2 RO.
- response  out  1  1 iff count_a > count_b.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; synchronizers, edge-history flops and latched sel/window registers cleared.
- Input path: ro1_in[sel_a_q] and ro2_in[sel_b_q] are muxed, then each passes a 2-flop synchronizer, then a history flop.
  - A rising edge is counted when sync=1 and hist=0.
  - Exact counts are guaranteed only for RO high and low phases of at least 2 clk cycles. Faster ROs alias; the result is still deterministic per device.
- FSM states: IDLE, WARMUP, COUNT, DONE.
- IDLE:
  - Accepting start: if start=1 at edge k, latch sel_a, sel_b, window, clear both counters and go to WARMUP.
  - Otherwise start is ignored.
- WARMUP:
  - ro_activate_1 and ro_activate_2 = 1; busy = 1; no counting.
  - Stays SETTLE cycles (cycles k+1 .. k+SETTLE) so the synchronizers flush stale values, then goes to COUNT.
  - If window_q = 0: skip COUNT and go to DONE; counts stay 0.
- COUNT:
  - Activates = 1; busy = 1; exactly window_q cycles.
  - Each cycle, each counter increments by 1 on its detected edge.
  - Counters saturate at 2^CNT_W-1; they never wrap.
  - Then goes to DONE.
- DONE: exactly one cycle.
  - done = 1, busy = 0, activates = 0.
  - response = (count_a > count_b); a tie gives 0.
  - Then returns to IDLE.
- done timing: done is high in cycle k+1+SETTLE+window_q.
- count_a, count_b and response hold their values until the next accepted start.
  - count_a and count_b clear at the start of WARMUP.
  - response is updated only in DONE.
- start asserted while busy or in DONE: ignored, not queued.
- sel/window changes after acceptance: no effect on the running measurement.
- rst mid-measurement: immediate return to IDLE; activates drop asynchronously; counts and response go to 0; no done pulse.

Test Plan:
1. Reset values: assert rst mid-run with arbitrary inputs -> all outputs 0 immediately; IDLE after release; start next cycle is accepted.
2. Basic compare:
   - Stimulus: ro1_in[2] period 8 clk, ro2_in[5] period 4 clk (both free-running); start with sel_a=2, sel_b=5, window=64.
   - Required: count_a=8, count_b=16, response=0, done exactly at cycle k+69 (SETTLE=4); activates high in cycles k+1..k+68.
3. Swap/tie:
   - Swap periods -> count_a=16, count_b=8, response=1.
   - Equal period 8 on both -> 8/8, response=0.
4. Saturation: CNT_W=4, period 4, window=128 -> 32 edges clamp to count_a=15, count_b=15, response=0.
5. Protocol:
   - start held high through a measurement, window=16 -> exactly one done pulse per accepted start; retriggers on the IDLE cycle after DONE.
   - sel/window changed mid-run -> no effect on the running measurement.
6. Edge cases:
   - window=0 -> done at k+5, counts 0, response 0.
   - rst at COUNT midpoint -> activates 0 same cycle, no done pulse.
